// File: rtl/lcd_controller.sv
// Plays each word stored to the LCD register out as a timed HD44780-style write cycle.
// Optional power-up init sequence (0x38, 0x0C, 0x01, 0x06) is enabled with LCD_INIT_EN.
module lcd_controller #(
    parameter int unsigned T_SETUP_CYC   = 2,
    parameter int unsigned T_EN_CYC      = 12,
    parameter int unsigned T_HOLD_CYC    = 2,
    parameter int unsigned T_EXEC_CYC    = 2000,
    parameter int unsigned T_CLEAR_CYC   = 82000,
`ifdef LCD_INIT_EN
    parameter int unsigned T_POWERUP_CYC = 750000,
`endif
    parameter int unsigned CNT_W         = 20
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_lcd_wr,
    input  logic [31:0] i_lcd_word,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_busy,
    output logic        o_overrun
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StPulse,
        StHold,
        StExec
`ifdef LCD_INIT_EN
        , StInitWait
`endif
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       data_q;
    logic             rs_q;
    logic             en_q;
    logic             on_q;
    logic             busy_q;
    logic             overrun_q;
    logic             pend_valid_q;
    logic             pend_rs_q;
    logic [7:0]       pend_data_q;

    logic             wr_cmd;
    logic             exec_done;
    logic             is_clear;
    logic             issue;
    logic             issue_rs;
    logic [7:0]       issue_data;
    logic             take_word;
    logic             drain;
    logic             unused_word;

    assign unused_word = ^i_lcd_word[30:10];

    assign wr_cmd    = i_lcd_wr & ~i_lcd_word[8];
    assign exec_done = (state_q == StExec) && (cnt_q == '0);
    // Clear/home commands need the long execution wait
    assign is_clear  = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);

`ifdef LCD_INIT_EN
    logic       init_active_q;
    logic [1:0] init_idx_q;
    logic       init_more;

    assign init_more = init_active_q && (init_idx_q != 2'd3);

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h01;
            default: init_cmd = 8'h06;
        endcase
    endfunction
`endif

    // Selects the word that starts a new bus cycle on this edge, if any
    always_comb begin
        issue      = 1'b0;
        issue_rs   = i_lcd_word[9];
        issue_data = i_lcd_word[7:0];
        take_word  = 1'b0;
        drain      = 1'b0;
        if (state_q == StIdle && wr_cmd) begin
            issue     = 1'b1;
            take_word = 1'b1;
        end
`ifdef LCD_INIT_EN
        else if (state_q == StInitWait && cnt_q == '0) begin
            issue      = 1'b1;
            issue_rs   = 1'b0;
            issue_data = init_cmd(2'd0);
        end
        else if (exec_done && init_more) begin
            issue      = 1'b1;
            issue_rs   = 1'b0;
            issue_data = init_cmd(init_idx_q + 2'd1);
        end
`endif
        else if (exec_done && pend_valid_q) begin
            issue      = 1'b1;
            drain      = 1'b1;
            issue_rs   = pend_rs_q;
            issue_data = pend_data_q;
        end
        else if (exec_done && wr_cmd) begin
            issue     = 1'b1;
            take_word = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            data_q       <= '0;
            rs_q         <= 1'b0;
            en_q         <= 1'b0;
            on_q         <= 1'b0;
            overrun_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_rs_q    <= 1'b0;
            pend_data_q  <= '0;
`ifdef LCD_INIT_EN
            state_q       <= StInitWait;
            cnt_q         <= CNT_W'(T_POWERUP_CYC - 1);
            busy_q        <= 1'b1;
            init_active_q <= 1'b1;
            init_idx_q    <= 2'd0;
`else
            state_q      <= StIdle;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
`endif
        end else begin
            if (i_lcd_wr) begin
                on_q <= i_lcd_word[31];
            end

            if (drain) begin
                pend_valid_q <= 1'b0;
            end
            if (wr_cmd && !take_word) begin
                if (!pend_valid_q || drain) begin
                    pend_valid_q <= 1'b1;
                    pend_rs_q    <= i_lcd_word[9];
                    pend_data_q  <= i_lcd_word[7:0];
                end else begin
                    overrun_q <= 1'b1;
                end
            end

`ifdef LCD_INIT_EN
            if (exec_done && init_active_q) begin
                if (init_idx_q == 2'd3) begin
                    init_active_q <= 1'b0;
                end else begin
                    init_idx_q <= init_idx_q + 2'd1;
                end
            end
`endif

            case (state_q)
                StIdle: ;
                StSetup: begin
                    if (cnt_q == '0) begin
                        state_q <= StPulse;
                        cnt_q   <= CNT_W'(T_EN_CYC - 1);
                        en_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StPulse: begin
                    if (cnt_q == '0) begin
                        state_q <= StHold;
                        cnt_q   <= CNT_W'(T_HOLD_CYC - 1);
                        en_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StHold: begin
                    if (cnt_q == '0) begin
                        state_q <= StExec;
                        cnt_q   <= is_clear ? CNT_W'(T_CLEAR_CYC - 1) : CNT_W'(T_EXEC_CYC - 1);
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StExec: begin
                    if (cnt_q == '0) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
`ifdef LCD_INIT_EN
                StInitWait: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase

            // A new cycle overrides whatever the state case decided
            if (issue) begin
                state_q <= StSetup;
                cnt_q   <= CNT_W'(T_SETUP_CYC - 1);
                rs_q    <= issue_rs;
                data_q  <= issue_data;
                busy_q  <= 1'b1;
            end
        end
    end

    assign o_lcd_data = data_q;
    assign o_lcd_rs   = rs_q;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = en_q;
    assign o_lcd_on   = on_q;
    assign o_busy     = busy_q;
    assign o_overrun  = overrun_q;

endmodule

// File: doc/lcd_controller.md
Name: lcd_controller

Overview:
- Consumer end of the memory-mapped LCD register written by the load/store unit.
- Takes each 32-bit word stored to the LCD I/O address and plays it out as a timed HD44780-style parallel write cycle.
- Drives the LCD pins, reports busy status for software polling, and absorbs one back-to-back write in a 1-deep pending buffer.

Parameters:
- T_SETUP_CYC, 2: cycles RS/DATA are held stable before EN rises.
- T_EN_CYC, 12: cycles EN is held high.
- T_HOLD_CYC, 2: cycles RS/DATA are held after EN falls.
- T_EXEC_CYC, 2000: post-write wait for normal commands and data.
- T_CLEAR_CYC, 82000: post-write wait for clear/home commands.
- T_POWERUP_CYC, 750000: power-up wait, used only with LCD_INIT_EN.
- CNT_W, 20: timing counter width; must hold the largest T_* value.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_lcd_wr  in  1  one-cycle strobe: LSU store to the LCD address
- i_lcd_word  in  32  stored word. Bit 31 = ON, bit 9 = RS, bit 8 = NOP (update ON only), bits 7:0 = DATA.
- o_lcd_data  out  8  LCD data bus
- o_lcd_rs  out  1  register select
- o_lcd_rw  out  1  read/write; tied 0 (write-only)
- o_lcd_en  out  1  enable strobe
- o_lcd_on  out  1  LCD power/backlight
- o_busy  out  1  controller busy (readable by software)
- o_overrun  out  1  sticky flag: a write was dropped

Behaviour:
- Reset: all outputs are 0. State goes to IDLE (or INIT_WAIT with LCD_INIT_EN), the pending buffer is cleared and the counter is cleared.
- Reset mid-cycle takes effect on the next edge: EN drops immediately and no partial cycle completes.
- o_lcd_on loads i_lcd_word[31] on every i_lcd_wr, including writes that are dropped.
- A NOP write (bit 8 = 1) only updates ON: no bus cycle, no buffer entry, no effect on busy.
- States and transitions:
  - IDLE: a non-NOP write latches RS/DATA and moves to SETUP on the next edge.
  - SETUP: EN = 0 for T_SETUP_CYC cycles, then PULSE.
  - PULSE: EN = 1 for T_EN_CYC cycles, then HOLD.
  - HOLD: EN = 0 for T_HOLD_CYC cycles, then EXEC.
  - EXEC: wait T_wait cycles. T_wait = T_CLEAR_CYC when RS = 0 and DATA is 0x01, 0x02 or 0x03; otherwise T_EXEC_CYC.
- End of EXEC: if the pending buffer is valid, go to SETUP with the pending word and clear pending; otherwise go to IDLE.
- Latency: write accepted at edge k gives DATA/RS valid from k+1 and EN rising at k+1+T_SETUP_CYC.
- o_busy is high from k+1 for exactly T_SETUP_CYC+T_EN_CYC+T_HOLD_CYC+T_wait cycles, and stays high continuously across chained pending words.
- RS/DATA outputs hold their last value while IDLE.
- Write while busy, pending empty: the word is stored in pending.
- Write while busy, pending full: the word is dropped (ON still updates) and o_overrun is set. o_overrun is cleared only by reset.
- A write in the final EXEC cycle with pending empty is stored and issued next with no IDLE cycle; o_busy does not drop.
- Counter counts down from the loaded T_*-1 to 0; there is no wrap, because it is reloaded on every state entry.

Optional Feature:
- Macro LCD_INIT_EN.
- Defined: after reset, enter INIT_WAIT and hold for T_POWERUP_CYC cycles, then issue commands 0x38, 0x0C, 0x01, 0x06 (RS = 0) using the normal SETUP/PULSE/HOLD/EXEC timing, then go to IDLE.
  - o_busy is high throughout the init sequence.
  - User writes during init follow the pending/overrun rules and are issued after 0x06 completes.
- Not defined: INIT states are absent and the controller leaves reset in IDLE.

Test Plan:
- Simulation parameters for all scenarios: T_SETUP_CYC = 2, T_EN_CYC = 4, T_HOLD_CYC = 2, T_EXEC_CYC = 10, T_CLEAR_CYC = 30.
- Write 0x8000_0241 in IDLE -> o_lcd_on = 1, rs = 1 and data = 0x41 on the next cycle; EN high for cycles 3-6 after accept; o_busy high for 18 cycles.
- Write 0x0000_0001 -> rs = 0, data = 0x01; o_busy high for 38 cycles. Write 0x0000_0038 -> o_busy high for 18 cycles.
- Writes of 0x241, 0x242, 0x243 on three consecutive cycles -> EN pulses with data 0x41 then 0x42, 0x43 is never driven, o_overrun = 1, o_busy high for 36 contiguous cycles.
- Write 0x8000_0100 -> o_lcd_on = 1, no EN pulse, o_busy stays 0; then write 0x0000_0100 -> o_lcd_on = 0.
- Assert i_reset during PULSE -> next edge: en = 0, busy = 0, on = 0, overrun = 0; a subsequent write runs a clean, full-length cycle.
- LCD_INIT_EN defined, T_POWERUP_CYC = 50 -> busy from reset; 50 cycles idle, then EN pulses with rs = 0 and data 0x38, 0x0C, 0x01, 0x06 in order; busy falls 50+18+18+38+18 cycles after reset.
